frame_selector: RTL and testbench
=================================

FRAME_SELECTOR -- requirements
Module: frame_selector

Interface
REQ-001 Parameter ROWS, default 8: matrix row count.
REQ-002 Parameter COLS, default 7: matrix column count.
REQ-003 Parameter NSRC, default 4, legal range 2..16: number of frame sources.
REQ-004 Parameter SEL_W, default 2: select width; SHALL equal ceil(log2(NSRC)).
REQ-005 Parameter DIV_W, default 24: period counter width.
REQ-006 Port clock, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1: reset, synchronous, active-high.
REQ-008 Port src_data, input, NSRC*ROWS*COLS: source frames, flattened; source k occupies bits [k*ROWS*COLS +: ROWS*COLS]; pixel (r,c) sits at offset r*COLS+c.
REQ-009 Port sel_req, input, 1: single-cycle select request.
REQ-010 Port sel_in, input, SEL_W: requested source, sampled when sel_req=1.
REQ-011 Port mode, input, 2: 0=STATIC, 1=BLINK, 2=ROTATE, 3=reserved (behaves as STATIC).
REQ-012 Port period, input, DIV_W: tick period in clocks; period=0 SHALL behave as period=1.
REQ-013 Port frame, output, ROWS*COLS: registered displayed frame.
REQ-014 Port active_src, output, SEL_W: source currently selected.
REQ-015 Port tick, output, 1: one-cycle pulse at each period boundary.
REQ-016 Port changed, output, 1: one-cycle pulse when frame takes a value different from its previous value.
REQ-017 Port sel_err, output, 1: one-cycle pulse when sel_req carries sel_in >= NSRC.

Function
REQ-018 Period counter SHALL count 0..max(period,1)-1 and wrap; tick SHALL assert in the cycle after the counter holds the terminal value.
REQ-019 A change of mode, detected by a registered copy of mode, SHALL clear the counter and the phase and SHALL suppress tick for that cycle.
REQ-020 Valid sel_req (sel_in < NSRC) SHALL load active_src on the next edge; the invalid case SHALL leave active_src unchanged and pulse sel_err on the next edge.
REQ-021 STATIC: frame SHALL equal src_data slice[active_src] registered, 1-clock latency from src_data or active_src.
REQ-022 BLINK: phase state machine with states SHOW and BLANK; each tick SHALL toggle the state; SHOW drives the selected slice, BLANK drives all zeros.
REQ-023 ROTATE: each tick SHALL advance active_src by 1, wrapping from NSRC-1 to 0; frame follows the new source with 1-clock latency.
REQ-024 A valid sel_req coinciding with a ROTATE tick SHALL take priority; active_src takes sel_in and is not incremented that cycle.
REQ-025 A change of period mid-count SHALL take effect immediately; if counter >= new period-1, the next cycle SHALL wrap and tick.
REQ-026 changed SHALL pulse on the edge after frame is updated to a differing value; it SHALL never pulse on reset.
REQ-027 Outside BLINK the phase SHALL be held at SHOW.

Reset
REQ-028 While reset=1 at an edge: frame=0, active_src=0, counter=0, phase=SHOW, tick=0, changed=0, sel_err=0; registered mode copy loads the current mode.
REQ-029 Reset SHALL override sel_req, tick and mode change in the same cycle; the first frame after deassertion SHALL appear one clock later.

Verification
REQ-030 STATIC, NSRC=4, sel_req with sel_in=2 -> active_src=2 next edge; frame=slice 2 one edge later; changed pulses once.
REQ-031 BLINK, period=3 -> tick every 3 clocks; frame alternates slice/zero every 3 clocks; changed pulses at each toggle.
REQ-032 ROTATE, period=1, NSRC=4 -> active_src sequence 0,1,2,3,0 on consecutive clocks.
REQ-033 ROTATE, sel_req sel_in=1 coinciding with tick while active_src=3 -> active_src=1, not 0.
REQ-034 sel_req with sel_in=5 at NSRC=4 -> sel_err=1 for one cycle; active_src unchanged.
REQ-035 Reset asserted mid-BLINK in BLANK -> all outputs 0 next edge; after release, phase=SHOW and counter restarts from 0.

Source files
------------

// File: rtl/frame_selector.sv
// Frame source selector: picks one of NSRC flattened frames and registers it,
// with static, blinking and rotating display modes driven by a period ticker.
//
// phase state | meaning
// ------------+-------------------------------------------
// PH_SHOW     | selected source slice is driven to frame
// PH_BLANK    | frame is driven to all zeros (BLINK only)
module frame_selector #(
    parameter int ROWS  = 8,
    parameter int COLS  = 7,
    parameter int NSRC  = 4,
    parameter int SEL_W = 2,
    parameter int DIV_W = 24
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NSRC*ROWS*COLS-1:0] src_data,
    input  logic                      sel_req,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [1:0]                mode,
    input  logic [DIV_W-1:0]          period,
    output logic [ROWS*COLS-1:0]      frame,
    output logic [SEL_W-1:0]          active_src,
    output logic                      tick,
    output logic                      changed,
    output logic                      sel_err
);

    localparam int          PIX         = ROWS * COLS;
    localparam logic [31:0] NSRC_U      = NSRC;
    localparam logic [1:0]  MODE_BLINK  = 2'd1;
    localparam logic [1:0]  MODE_ROTATE = 2'd2;
    localparam logic        PH_SHOW     = 1'b0;
    localparam logic        PH_BLANK    = 1'b1;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] term;
    logic [1:0]       mode_q;
    logic             phase;
    logic             diff;
    logic             mode_chg;
    logic             wrap;
    logic             sel_valid;
    logic [PIX-1:0]   slice;
    logic [PIX-1:0]   frame_next;
    logic [SEL_W-1:0] src_inc;

    always_comb begin
        // period 0 is treated as period 1, so the terminal count is 0 either way
        term       = (period == '0) ? '0 : period - DIV_W'(1);
        wrap       = (cnt >= term);
        mode_chg   = (mode != mode_q);
        sel_valid  = sel_req && (32'(sel_in) < NSRC_U);
        slice      = src_data[int'(active_src)*PIX +: PIX];
        src_inc    = (active_src == SEL_W'(NSRC - 1)) ? '0 : active_src + SEL_W'(1);
        frame_next = (phase == PH_BLANK) ? '0 : slice;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame      <= '0;
            active_src <= '0;
            cnt        <= '0;
            phase      <= PH_SHOW;
            tick       <= 1'b0;
            changed    <= 1'b0;
            sel_err    <= 1'b0;
            diff       <= 1'b0;
            mode_q     <= mode;
        end else begin
            mode_q  <= mode;
            sel_err <= sel_req && !sel_valid;

            if (mode_chg) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else begin
                cnt  <= wrap ? '0 : cnt + DIV_W'(1);
                tick <= wrap;
            end

            // an explicit select wins over the rotate step in the same cycle
            if (sel_valid)
                active_src <= sel_in;
            else if (mode == MODE_ROTATE && tick && !mode_chg)
                active_src <= src_inc;

            if (mode_chg || mode != MODE_BLINK)
                phase <= PH_SHOW;
            else if (tick)
                phase <= ~phase;

            frame   <= frame_next;
            diff    <= (frame_next != frame);
            changed <= diff;
        end
    end

endmodule

// File: tb/tb_frame_selector.sv
// Directed bench for frame_selector: reset, static select, blink, rotate,
// rotate/select priority, period change and invalid select handling.
module tb_frame_selector;

    localparam int PIX  = 56;
    localparam int PIX2 = 6;

    logic            clock = 1'b0;
    logic            reset;
    logic [4*PIX-1:0] src_data;
    logic            sel_req;
    logic [1:0]      sel_in;
    logic [1:0]      mode;
    logic [23:0]     period;
    logic [PIX-1:0]  frame;
    logic [1:0]      active_src;
    logic            tick, changed, sel_err;

    logic [5*PIX2-1:0] src_data2;
    logic              sel_req2;
    logic [2:0]        sel_in2;
    logic [PIX2-1:0]   frame2;
    logic [2:0]        active_src2;
    logic              tick2, changed2, sel_err2;

    int total = 0;
    int bad   = 0;

    localparam logic [PIX-1:0] S0 = 56'h01234567_89ABCD;
    localparam logic [PIX-1:0] S1 = 56'hFEDCBA98_765432;
    localparam logic [PIX-1:0] S2 = 56'h00FF00FF_00FF00;
    localparam logic [PIX-1:0] S3 = 56'h5A5A5A5A_A5A5A5;

    always #5 clock = ~clock;

    frame_selector dut (
        .clock(clock), .reset(reset), .src_data(src_data), .sel_req(sel_req),
        .sel_in(sel_in), .mode(mode), .period(period), .frame(frame),
        .active_src(active_src), .tick(tick), .changed(changed), .sel_err(sel_err)
    );

    frame_selector #(.ROWS(2), .COLS(3), .NSRC(5), .SEL_W(3), .DIV_W(24)) dut2 (
        .clock(clock), .reset(reset), .src_data(src_data2), .sel_req(sel_req2),
        .sel_in(sel_in2), .mode(mode), .period(period), .frame(frame2),
        .active_src(active_src2), .tick(tick2), .changed(changed2), .sel_err(sel_err2)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; mode = 2'd0; period = 24'd0; sel_req = 1'b0; sel_in = 2'd0;
        sel_req2 = 1'b0; sel_in2 = 3'd0;
        step(2);
        total++; if (frame !== '0) begin bad++; $display("FAIL reset_frame got=%h exp=0", frame); end
        total++; if (active_src !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", active_src); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", changed); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_selerr got=%b exp=0", sel_err); end
        reset = 1'b0;
        step(1);
        total++; if (frame !== S0) begin bad++; $display("FAIL first_frame got=%h exp=%h", frame, S0); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL first_changed_early got=%b exp=0", changed); end
        step(1);
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL first_changed got=%b exp=1", changed); end
        step(1);
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL first_changed_once got=%b exp=0", changed); end
    endtask

    task automatic test_static;
        sel_req = 1'b1; sel_in = 2'd2;
        step(1);
        sel_req = 1'b0;
        total++; if (active_src !== 2'd2) begin bad++; $display("FAIL static_src got=%0d exp=2", active_src); end
        total++; if (frame !== S0) begin bad++; $display("FAIL static_latency got=%h exp=%h", frame, S0); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL static_selerr got=%b exp=0", sel_err); end
        step(1);
        total++; if (frame !== S2) begin bad++; $display("FAIL static_frame got=%h exp=%h", frame, S2); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL static_changed_early got=%b exp=0", changed); end
        step(1);
        total++; if (changed !== 1'b1) begin bad++; $display("FAIL static_changed got=%b exp=1", changed); end
        step(1);
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL static_changed_once got=%b exp=0", changed); end
    endtask

    task automatic test_blink;
        bit exp_t [12] = '{0,0,0,1,0,0,1,0,0,1,0,0};
        bit exp_f [12] = '{1,1,1,1,1,0,0,0,1,1,1,0};
        bit exp_c [12] = '{0,0,0,0,0,0,1,0,0,1,0,0};
        logic [PIX-1:0] ef;
        mode = 2'd1; period = 24'd3;
        for (int i = 0; i < 12; i++) begin
            step(1);
            ef = exp_f[i] ? S2 : '0;
            total++; if (tick !== exp_t[i]) begin bad++; $display("FAIL blink_tick[%0d] got=%b exp=%b", i, tick, exp_t[i]); end
            total++; if (frame !== ef) begin bad++; $display("FAIL blink_frame[%0d] got=%h exp=%h", i, frame, ef); end
            total++; if (changed !== exp_c[i]) begin bad++; $display("FAIL blink_changed[%0d] got=%b exp=%b", i, changed, exp_c[i]); end
        end
    endtask

    task automatic test_reset_mid_blink;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total++; if (frame !== '0) begin bad++; $display("FAIL rst_blink_frame got=%h exp=0", frame); end
        total++; if (active_src !== 2'd0) begin bad++; $display("FAIL rst_blink_src got=%0d exp=0", active_src); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_blink_tick got=%b exp=0", tick); end
        total++; if (changed !== 1'b0) begin bad++; $display("FAIL rst_blink_changed got=%b exp=0", changed); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL rst_blink_selerr got=%b exp=0", sel_err); end
        step(1);
        total++; if (frame !== S0) begin bad++; $display("FAIL rst_blink_show got=%h exp=%h", frame, S0); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_blink_tick1 got=%b exp=0", tick); end
        step(1);
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_blink_tick2 got=%b exp=0", tick); end
        step(1);
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL rst_blink_tick3 got=%b exp=1", tick); end
    endtask

    task automatic test_rotate;
        logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mode = 2'd2; period = 24'd1;
        step(1);
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rot_modechg_tick got=%b exp=0", tick); end
        total++; if (active_src !== 2'd0) begin bad++; $display("FAIL rot_modechg_src got=%0d exp=0", active_src); end
        for (int i = 0; i < 5; i++) begin
            step(1);
            total++; if (active_src !== exp_s[i]) begin bad++; $display("FAIL rot_src[%0d] got=%0d exp=%0d", i, active_src, exp_s[i]); end
            if (i == 2) begin
                total++; if (frame !== S1) begin bad++; $display("FAIL rot_frame1 got=%h exp=%h", frame, S1); end
            end
            if (i == 3) begin
                total++; if (frame !== S2) begin bad++; $display("FAIL rot_frame2 got=%h exp=%h", frame, S2); end
            end
        end
    endtask

    task automatic test_back_to_back;
        step(3);
        total++; if (active_src !== 2'd3) begin bad++; $display("FAIL prio_setup got=%0d exp=3", active_src); end
        sel_req = 1'b1; sel_in = 2'd1;
        step(1);
        sel_req = 1'b0;
        total++; if (active_src !== 2'd1) begin bad++; $display("FAIL prio_src got=%0d exp=1", active_src); end
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL prio_tick got=%b exp=1", tick); end
        step(1);
        total++; if (active_src !== 2'd2) begin bad++; $display("FAIL prio_next got=%0d exp=2", active_src); end
    endtask

    task automatic test_period_change;
        bit exp_t [4] = '{1,0,0,1};
        mode = 2'd0; period = 24'd8;
        for (int i = 0; i < 6; i++) begin
            step(1);
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL per_count_tick[%0d] got=%b exp=0", i, tick); end
        end
        period = 24'd3;
        for (int i = 0; i < 4; i++) begin
            step(1);
            total++; if (tick !== exp_t[i]) begin bad++; $display("FAIL per_shrink_tick[%0d] got=%b exp=%b", i, tick, exp_t[i]); end
        end
    endtask

    task automatic test_sel_err;
        sel_req2 = 1'b1; sel_in2 = 3'd4;
        step(1);
        total++; if (active_src2 !== 3'd4) begin bad++; $display("FAIL err_valid_src got=%0d exp=4", active_src2); end
        total++; if (sel_err2 !== 1'b0) begin bad++; $display("FAIL err_valid_flag got=%b exp=0", sel_err2); end
        sel_in2 = 3'd5;
        step(1);
        sel_req2 = 1'b0;
        total++; if (sel_err2 !== 1'b1) begin bad++; $display("FAIL err_5_flag got=%b exp=1", sel_err2); end
        total++; if (active_src2 !== 3'd4) begin bad++; $display("FAIL err_5_src got=%0d exp=4", active_src2); end
        step(1);
        total++; if (sel_err2 !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", sel_err2); end
        sel_req2 = 1'b1; sel_in2 = 3'd7;
        step(1);
        sel_req2 = 1'b0;
        total++; if (sel_err2 !== 1'b1) begin bad++; $display("FAIL err_7_flag got=%b exp=1", sel_err2); end
        total++; if (active_src2 !== 3'd4) begin bad++; $display("FAIL err_7_src got=%0d exp=4", active_src2); end
    endtask

    initial begin
        src_data  = {S3, S2, S1, S0};
        src_data2 = 30'h2AB_CDEF1;
        test_reset;
        test_static;
        test_blink;
        test_reset_mid_blink;
        test_rotate;
        test_back_to_back;
        test_period_change;
        test_sel_err;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
